// File: rtl/fei4_cmd_pkg.sv
// FE-I4 DCI command encoding: command codes, header/field constants, frame builder.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package fei4_cmd_pkg;

  localparam int FRAME_W = 38;

  localparam logic [3:0] CMD_TRIG    = 4'd0;
  localparam logic [3:0] CMD_BCR     = 4'd1;
  localparam logic [3:0] CMD_ECR     = 4'd2;
  localparam logic [3:0] CMD_CAL     = 4'd3;
  localparam logic [3:0] CMD_RDREG   = 4'd4;
  localparam logic [3:0] CMD_WRREG   = 4'd5;
  localparam logic [3:0] CMD_GRST    = 4'd6;
  localparam logic [3:0] CMD_GPULSE  = 4'd7;
  localparam logic [3:0] CMD_RUNMODE = 4'd8;

  localparam logic [4:0] TRIG_HDR = 5'b11101;
  localparam logic [4:0] FAST_HDR = 5'b10110;
  localparam logic [3:0] SLOW_PFX = 4'b1000;

  localparam logic [3:0] FAST_BCR = 4'b0001;
  localparam logic [3:0] FAST_ECR = 4'b0010;
  localparam logic [3:0] FAST_CAL = 4'b0100;

  localparam logic [3:0] FLD_RDREG   = 4'b0001;
  localparam logic [3:0] FLD_WRREG   = 4'b0010;
  localparam logic [3:0] FLD_GRST    = 4'b1000;
  localparam logic [3:0] FLD_GPULSE  = 4'b1001;
  localparam logic [3:0] FLD_RUNMODE = 4'b1010;

  localparam logic [5:0] LEN_TRIG  = 6'd5;
  localparam logic [5:0] LEN_FAST  = 6'd9;
  localparam logic [5:0] LEN_SLOW  = 6'd22;
  localparam logic [5:0] LEN_WRREG = 6'd38;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  // Frames are left-aligned so the MSB is always the first bit on the wire.
  typedef struct packed {
    logic               legal;
    logic [5:0]         len;
    logic [FRAME_W-1:0] bits;
  } frame_t;

  function automatic frame_t build_frame(input logic [3:0]  typ,
                                         input logic [2:0]  chip,
                                         input logic [5:0]  addr,
                                         input logic [15:0] data);
    frame_t f;
    f.legal = 1'b1;
    f.len   = LEN_SLOW;
    f.bits  = '0;
    case (typ)
      CMD_TRIG:    begin f.len = LEN_TRIG; f.bits = {TRIG_HDR, 33'd0}; end
      CMD_BCR:     begin f.len = LEN_FAST; f.bits = {FAST_HDR, FAST_BCR, 29'd0}; end
      CMD_ECR:     begin f.len = LEN_FAST; f.bits = {FAST_HDR, FAST_ECR, 29'd0}; end
      CMD_CAL:     begin f.len = LEN_FAST; f.bits = {FAST_HDR, FAST_CAL, 29'd0}; end
      CMD_RDREG:   f.bits = {FAST_HDR, SLOW_PFX, FLD_RDREG, chip, addr, 16'd0};
      CMD_WRREG:   begin f.len = LEN_WRREG; f.bits = {FAST_HDR, SLOW_PFX, FLD_WRREG, chip, addr, data}; end
      CMD_GRST:    f.bits = {FAST_HDR, SLOW_PFX, FLD_GRST, chip, 6'd0, 16'd0};
      CMD_GPULSE:  f.bits = {FAST_HDR, SLOW_PFX, FLD_GPULSE, chip, addr, 16'd0};
      CMD_RUNMODE: f.bits = {FAST_HDR, SLOW_PFX, FLD_RUNMODE, chip,
                             (data[0] ? 6'b111000 : 6'b000111), 16'd0};
      default:     begin f.legal = 1'b0; f.len = 6'd0; end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fei4_cmd_tx_if.sv
// Command request / trigger / serial output bundle of the DCI transmitter.
// Latency: none (wiring only).
// Backpressure: CmdValid is held until CmdReady; triggers are never backpressured.
interface fei4_cmd_tx_if;
  logic [2:0]  ChipId;
  logic        CmdValid;
  logic        CmdReady;
  logic [3:0]  CmdType;
  logic [5:0]  CmdAddr;
  logic [15:0] CmdData;
  logic        TrigReq;
  logic [3:0]  TrigPending;
  logic        TrigDropped;
  logic        Busy;
  logic        DCI;

  modport master (
    output ChipId, CmdValid, CmdType, CmdAddr, CmdData, TrigReq,
    input  CmdReady, TrigPending, TrigDropped, Busy, DCI
  );

  modport slave (
    input  ChipId, CmdValid, CmdType, CmdAddr, CmdData, TrigReq,
    output CmdReady, TrigPending, TrigDropped, Busy, DCI
  );
endinterface

// File: rtl/fei4_cmd_shifter.sv
// 38-bit load/shift register with bit down-counter; MSB is the serial bit.
// Latency: loaded frame MSB visible the cycle after load.
// Backpressure: none; load wins over shift.
module fei4_cmd_shifter
  import fei4_cmd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [5:0]         i_len,
  output logic               o_msb,
  output logic               o_last
);
  logic [FRAME_W-1:0] r_sh;
  logic [5:0]         r_cnt;

  // Load a left-aligned frame or shift zeros in behind it, counting bits left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_frame;
      r_cnt <= i_len - 6'd1;
    end else if (i_shift) begin
      r_sh <= {r_sh[FRAME_W-2:0], 1'b0};
      if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
    end
  end

  // Zeros trail every frame, so the MSB is already 0 in gap and idle cycles.
  assign o_msb  = r_sh[FRAME_W-1];
  assign o_last = (r_cnt == 6'd0);
endmodule

// File: rtl/fei4_cmd_tx.sv
// FE-I4 DCI command transmitter: trigger/fast/slow frames, MSB first, GAP zeros after each.
// Latency: first frame bit on DCI the cycle after acceptance or trigger start.
// Backpressure: CmdReady only in IDLE with no pending trigger; triggers queue up to TRIG_DEPTH.
module fei4_cmd_tx
  import fei4_cmd_pkg::*;
#(
  parameter int GAP        = 2,
  parameter int TRIG_DEPTH = 15
) (
  input  logic          i_CK,
  input  logic          i_RstB,
  fei4_cmd_tx_if.slave  bus
);
  localparam logic [3:0]         GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic [3:0]         TRIG_MAX  = 4'(TRIG_DEPTH);
  localparam logic [FRAME_W-1:0] TRIG_BITS = {TRIG_HDR, 33'd0};

  state_t             r_state;
  logic [3:0]         r_gap_cnt;
  logic [3:0]         r_trig_cnt;
  logic               r_drop;
  frame_t             w_cmd_frame;
  logic [FRAME_W-1:0] w_bits;
  logic [5:0]         w_len;
  logic               w_idle, w_frame_end, w_trig_start, w_cmd_rdy;
  logic               w_accept, w_load, w_shift, w_msb, w_last;

  assign w_idle      = (r_state == ST_IDLE);
  // Last cycle of the trailing gap (or of the frame itself when GAP is 0);
  // a queued trigger chains straight on so triggers run back to back.
  assign w_frame_end = ((r_state == ST_GAP) && (r_gap_cnt == 4'd0)) ||
                       ((r_state == ST_SHIFT) && w_last && (GAP == 0));
  assign w_trig_start = (r_trig_cnt != 4'd0) && (w_idle || w_frame_end);
  assign w_cmd_rdy    = i_RstB && w_idle && (r_trig_cnt == 4'd0);
  assign w_accept     = bus.CmdValid && w_cmd_rdy;

  assign w_cmd_frame = build_frame(bus.CmdType, bus.ChipId, bus.CmdAddr, bus.CmdData);
  assign w_bits      = w_trig_start ? TRIG_BITS : w_cmd_frame.bits;
  assign w_len       = w_trig_start ? LEN_TRIG  : w_cmd_frame.len;
  // Illegal codes complete the handshake but never load anything.
  assign w_load      = w_trig_start || (w_accept && w_cmd_frame.legal);
  assign w_shift     = (r_state == ST_SHIFT) && !w_load;

  fei4_cmd_shifter u_shifter (
    .i_clk   (i_CK),
    .i_rst_n (i_RstB),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_frame (w_bits),
    .i_len   (w_len),
    .o_msb   (w_msb),
    .o_last  (w_last)
  );

  // Frame sequencer: start on load, shift to the last bit, then pad with GAP zeros.
  always_ff @(posedge i_CK or negedge i_RstB) begin
    if (!i_RstB) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_load) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_last) begin
            if (GAP == 0) begin
              r_state <= w_trig_start ? ST_SHIFT : ST_IDLE;
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_LAST;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) r_state <= w_trig_start ? ST_SHIFT : ST_IDLE;
          else                   r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pending-trigger counter: +1 per request, -1 per start, saturating with a drop pulse.
  always_ff @(posedge i_CK or negedge i_RstB) begin
    if (!i_RstB) begin
      r_trig_cnt <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (bus.TrigReq && !w_trig_start) begin
        if (r_trig_cnt == TRIG_MAX) r_drop     <= 1'b1;
        else                        r_trig_cnt <= r_trig_cnt + 4'd1;
      end else if (!bus.TrigReq && w_trig_start) begin
        r_trig_cnt <= r_trig_cnt - 4'd1;
      end
    end
  end

  assign bus.CmdReady    = w_cmd_rdy;
  assign bus.TrigPending = r_trig_cnt;
  assign bus.TrigDropped = r_drop;
  assign bus.Busy        = !w_idle;
  assign bus.DCI         = w_msb;
endmodule
